// File: rtl/reorder_buffer.sv
// Purpose : in-order retirement buffer for an out-of-order RV32 core. Entries are allocated
//           at dispatch, completed from the CDB, and retired in order, one per cycle.
// Latency : lookups are combinational with CDB bypass; commit pulses are registered (1 cycle).
// Backpr. : rob_full_out stalls the decoder; rdy_in low freezes all state, including the pulses.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   dispatcher_rob_*_in        : allocate one entry at the tail (tag on rob_dispatcher_b_out)
//   dispatcher_rob_r{s,t}_h_in : two operand lookups -> rob_dispatcher_r{s,t}_{ready,value}_out
//   cdb_rob_*_in               : result broadcast (value and actual next PC)
//   rob_regfile_*_out          : register write at commit
//   rob_store_*_out            : store release at commit
//   rob_flush_*_out            : mispredict recovery with redirect PC

`ifndef ROBWidth
`define ROBWidth 4
`endif
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef RegWidth
`define RegWidth 5
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif

module reorder_buffer (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,

    input  logic                      dispatcher_rob_en_in,
    input  logic [`InstTypeWidth-1:0] dispatcher_rob_opcode_in,
    input  logic [`RegWidth-1:0]      dispatcher_rob_dest_in,
    input  logic [`AddressWidth-1:0]  dispatcher_rob_target_in,
    input  logic [`AddressWidth-1:0]  dispatcher_rob_pc_in,
    input  logic                      dispatcher_rob_taken_in,
    output logic [`ROBWidth-1:0]      rob_dispatcher_b_out,
    output logic                      rob_full_out,

    input  logic [`ROBWidth-1:0]      dispatcher_rob_rs_h_in,
    output logic                      rob_dispatcher_rs_ready_out,
    output logic [`IDWidth-1:0]       rob_dispatcher_rs_value_out,
    input  logic [`ROBWidth-1:0]      dispatcher_rob_rt_h_in,
    output logic                      rob_dispatcher_rt_ready_out,
    output logic [`IDWidth-1:0]       rob_dispatcher_rt_value_out,

    input  logic                      cdb_rob_en_in,
    input  logic [`ROBWidth-1:0]      cdb_rob_tag_in,
    input  logic [`IDWidth-1:0]       cdb_rob_value_in,
    input  logic [`AddressWidth-1:0]  cdb_rob_npc_in,

    output logic                      rob_regfile_en_out,
    output logic [`RegWidth-1:0]      rob_regfile_rd_out,
    output logic [`IDWidth-1:0]       rob_regfile_value_out,
    output logic [`ROBWidth-1:0]      rob_regfile_tag_out,

    output logic                      rob_store_en_out,
    output logic [`ROBWidth-1:0]      rob_store_tag_out,

    output logic                      rob_flush_out,
    output logic [`AddressWidth-1:0]  rob_flush_pc_out
);

    localparam int ROB   = `ROBWidth;
    localparam int ID    = `IDWidth;
    localparam int REG   = `RegWidth;
    localparam int ADDR  = `AddressWidth;
    localparam int OP    = `InstTypeWidth;
    localparam int DEPTH = 1 << ROB;

    // Slot 0 is reserved as "no producer", so only DEPTH-1 tags circulate.
    localparam logic [ROB-1:0] FIRST_TAG = ROB'(1);
    localparam logic [ROB-1:0] LAST_TAG  = ROB'(DEPTH - 1);

    // Instruction-type encoding shared with the decoder.
    localparam logic [OP-1:0] OPC_JALR = OP'(4);
    localparam logic [OP-1:0] OPC_BEQ  = OP'(5);
    localparam logic [OP-1:0] OPC_BGEU = OP'(10);
    localparam logic [OP-1:0] OPC_SB   = OP'(16);
    localparam logic [OP-1:0] OPC_SW   = OP'(18);

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [OP-1:0]   op;
        logic [REG-1:0]  dest;
        logic [ADDR-1:0] pc;
        logic [ADDR-1:0] pred_npc;
        logic [ADDR-1:0] act_npc;
        logic [ID-1:0]   value;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic [ROB-1:0]  head_q,  head_d;
    logic [ROB-1:0]  tail_q,  tail_d;
    logic [ROB-1:0]  count_q, count_d;

    logic            reg_en_q,    reg_en_d;
    logic [REG-1:0]  reg_rd_q,    reg_rd_d;
    logic [ID-1:0]   reg_val_q,   reg_val_d;
    logic [ROB-1:0]  reg_tag_q,   reg_tag_d;
    logic            st_en_q,     st_en_d;
    logic [ROB-1:0]  st_tag_q,    st_tag_d;
    logic            flush_q,     flush_d;
    logic [ADDR-1:0] flush_pc_q,  flush_pc_d;

    logic            full;
    logic            commit_fire;
    logic            disp_fire;
    logic            mispredict;
    logic            head_is_br;
    logic            head_is_st;
    logic            head_is_jalr;
    entry_t          head_ent;

    function automatic logic [ROB-1:0] next_tag(input logic [ROB-1:0] t);
        return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
    endfunction

    assign full     = (count_q == LAST_TAG);
    assign head_ent = ent_q[head_q];

    assign head_is_br   = (head_ent.op >= OPC_BEQ) && (head_ent.op <= OPC_BGEU);
    assign head_is_st   = (head_ent.op >= OPC_SB)  && (head_ent.op <= OPC_SW);
    assign head_is_jalr = (head_ent.op == OPC_JALR);

    // rdy_in gating is applied at the register stage, so these are "would fire" terms.
    assign commit_fire = (count_q != '0) && head_ent.ready;
    assign mispredict  = commit_fire && (head_is_br || head_is_jalr)
                         && (head_ent.act_npc != head_ent.pred_npc);
    // Dispatches alongside a recovering commit, or while the flush pulse is out, are
    // wrong-path and must not consume a tag.
    assign disp_fire   = dispatcher_rob_en_in && !full && !mispredict && !flush_q;

    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        reg_en_d   = 1'b0;
        reg_rd_d   = reg_rd_q;
        reg_val_d  = reg_val_q;
        reg_tag_d  = reg_tag_q;
        st_en_d    = 1'b0;
        st_tag_d   = st_tag_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;

        // Completion first, so a retiring head below overrides any late write to it.
        if (cdb_rob_en_in && (cdb_rob_tag_in != '0) && ent_q[cdb_rob_tag_in].busy) begin
            ent_d[cdb_rob_tag_in].ready   = 1'b1;
            ent_d[cdb_rob_tag_in].value   = cdb_rob_value_in;
            ent_d[cdb_rob_tag_in].act_npc = cdb_rob_npc_in;
        end

        if (commit_fire) begin
            ent_d[head_q].busy  = 1'b0;
            ent_d[head_q].ready = 1'b0;
            head_d              = next_tag(head_q);
            if (head_is_st) begin
                st_en_d  = 1'b1;
                st_tag_d = head_q;
            end else if (!head_is_br && (head_ent.dest != '0)) begin
                reg_en_d  = 1'b1;
                reg_rd_d  = head_ent.dest;
                reg_val_d = head_ent.value;
                reg_tag_d = head_q;
            end
            if (mispredict) begin
                flush_d    = 1'b1;
                flush_pc_d = head_ent.act_npc;
            end
        end

        if (disp_fire) begin
            ent_d[tail_q].busy     = 1'b1;
            ent_d[tail_q].ready    = 1'b0;
            ent_d[tail_q].op       = dispatcher_rob_opcode_in;
            ent_d[tail_q].dest     = dispatcher_rob_dest_in;
            ent_d[tail_q].pc       = dispatcher_rob_pc_in;
            ent_d[tail_q].pred_npc = dispatcher_rob_taken_in ? dispatcher_rob_target_in
                                                             : dispatcher_rob_pc_in + ADDR'(4);
            ent_d[tail_q].act_npc  = '0;
            ent_d[tail_q].value    = '0;
            tail_d                 = next_tag(tail_q);
        end

        count_d = count_q + {{(ROB-1){1'b0}}, disp_fire} - {{(ROB-1){1'b0}}, commit_fire};

        if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end
            head_d  = FIRST_TAG;
            tail_d  = FIRST_TAG;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q     <= FIRST_TAG;
            tail_q     <= FIRST_TAG;
            count_q    <= '0;
            reg_en_q   <= 1'b0;
            reg_rd_q   <= '0;
            reg_val_q  <= '0;
            reg_tag_q  <= '0;
            st_en_q    <= 1'b0;
            st_tag_q   <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (rdy_in) begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            reg_en_q   <= reg_en_d;
            reg_rd_q   <= reg_rd_d;
            reg_val_q  <= reg_val_d;
            reg_tag_q  <= reg_tag_d;
            st_en_q    <= st_en_d;
            st_tag_q   <= st_tag_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Operand lookup: the value is only meaningful once ready, so it reads as 0 otherwise.
    logic rs_bypass, rt_bypass;
    assign rs_bypass = cdb_rob_en_in && (cdb_rob_tag_in != '0)
                       && (cdb_rob_tag_in == dispatcher_rob_rs_h_in);
    assign rt_bypass = cdb_rob_en_in && (cdb_rob_tag_in != '0)
                       && (cdb_rob_tag_in == dispatcher_rob_rt_h_in);

    always_comb begin
        rob_dispatcher_rs_ready_out = 1'b0;
        rob_dispatcher_rs_value_out = '0;
        if (dispatcher_rob_rs_h_in != '0) begin
            if (rs_bypass) begin
                rob_dispatcher_rs_ready_out = 1'b1;
                rob_dispatcher_rs_value_out = cdb_rob_value_in;
            end else if (ent_q[dispatcher_rob_rs_h_in].ready) begin
                rob_dispatcher_rs_ready_out = 1'b1;
                rob_dispatcher_rs_value_out = ent_q[dispatcher_rob_rs_h_in].value;
            end
        end
    end

    always_comb begin
        rob_dispatcher_rt_ready_out = 1'b0;
        rob_dispatcher_rt_value_out = '0;
        if (dispatcher_rob_rt_h_in != '0) begin
            if (rt_bypass) begin
                rob_dispatcher_rt_ready_out = 1'b1;
                rob_dispatcher_rt_value_out = cdb_rob_value_in;
            end else if (ent_q[dispatcher_rob_rt_h_in].ready) begin
                rob_dispatcher_rt_ready_out = 1'b1;
                rob_dispatcher_rt_value_out = ent_q[dispatcher_rob_rt_h_in].value;
            end
        end
    end

    assign rob_dispatcher_b_out  = tail_q;
    assign rob_full_out          = full;
    assign rob_regfile_en_out    = reg_en_q;
    assign rob_regfile_rd_out    = reg_rd_q;
    assign rob_regfile_value_out = reg_val_q;
    assign rob_regfile_tag_out   = reg_tag_q;
    assign rob_store_en_out      = st_en_q;
    assign rob_store_tag_out     = st_tag_q;
    assign rob_flush_out         = flush_q;
    assign rob_flush_pc_out      = flush_pc_q;

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Widths SHALL come from constant.vh: ROB=`ROBWidth (4), ID=`IDWidth (32), REG=`RegWidth (5), ADDR=`AddressWidth (32), OP=`InstTypeWidth.
REQ-002 clk_in  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_in  in  1  reset, synchronous, active-high.
REQ-004 rdy_in  in  1  global enable; low freezes all state.
REQ-005 dispatcher_rob_en_in  in  1  allocate one entry this cycle.
REQ-006 dispatcher_rob_opcode_in  in  OP  instruction type.
REQ-007 dispatcher_rob_dest_in  in  REG  destination register.
REQ-008 dispatcher_rob_target_in  in  ADDR  predicted-taken target.
REQ-009 dispatcher_rob_pc_in  in  ADDR  instruction PC.
REQ-010 dispatcher_rob_taken_in  in  1  predictor decision.
REQ-011 rob_dispatcher_b_out  out  ROB  tag the next allocation receives (tail).
REQ-012 rob_full_out  out  1  no free entry; decoder stalls.
REQ-013 dispatcher_rob_rs_h_in  in  ROB  first lookup tag.
REQ-014 rob_dispatcher_rs_ready_out  out  1  first lookup value available.
REQ-015 rob_dispatcher_rs_value_out  out  ID  first lookup value.
REQ-016 dispatcher_rob_rt_h_in  in  ROB  second lookup tag.
REQ-017 rob_dispatcher_rt_ready_out  out  1  second lookup value available.
REQ-018 rob_dispatcher_rt_value_out  out  ID  second lookup value.
REQ-019 cdb_rob_en_in  in  1  result broadcast valid.
REQ-020 cdb_rob_tag_in  in  ROB  producing entry.
REQ-021 cdb_rob_value_in  in  ID  result value (link value for JALR).
REQ-022 cdb_rob_npc_in  in  ADDR  actual next PC (BEQ..BGEU, JALR only).
REQ-023 rob_regfile_en_out  out  1  register commit pulse.
REQ-024 rob_regfile_rd_out  out  REG  committed register.
REQ-025 rob_regfile_value_out  out  ID  committed value.
REQ-026 rob_regfile_tag_out  out  ROB  committed tag; regfile clears busy only if its reorder field matches.
REQ-027 rob_store_en_out  out  1  store commit pulse to load/store buffer.
REQ-028 rob_store_tag_out  out  ROB  committed store tag.
REQ-029 rob_flush_out  out  1  mispredict flush pulse to all units.
REQ-030 rob_flush_pc_out  out  ADDR  fetch redirect PC.

Function
REQ-031 Circular buffer SHALL use tags 1..15 (tag 0 = "no producer", never allocated); head/tail advance 15->1; occupancy count 0..15; rob_full_out = (count==15), combinational.
REQ-032 Dispatch (en, rdy_in, not full, no flush) SHALL write entry[tail] busy, not ready, with opcode/dest/pc and predicted npc = taken ? target : pc+4; tail advances; dispatch while full or during flush SHALL be dropped.
REQ-033 CDB write with tag!=0 to a busy entry SHALL set ready, value, actual npc; tag 0 or non-busy tag ignored.
REQ-034 Lookups SHALL be combinational: tag 0 -> ready 0, value 0; same-cycle CDB write to the looked-up tag -> ready 1, CDB value (bypass); else entry ready/value.
REQ-035 Commit: at most one per cycle; when rdy_in, count>0 and head ready, retire head; commit outputs SHALL be registered, high exactly one cycle after the retiring edge.
REQ-036 Non-branch, non-store with dest!=0 SHALL pulse rob_regfile_en_out (rd, value, tag); dest 0 writes nothing; SB..SW pulse rob_store_en_out only; BEQ..BGEU write nothing.
REQ-037 BEQ..BGEU/JALR with actual npc != predicted npc SHALL pulse rob_flush_out with flush_pc = actual npc, clear all entries, head=tail=1, count=0; a JALR flushing still writes rd.
REQ-038 Simultaneous dispatch and commit SHALL leave count unchanged; with rdy_in low no pointer, entry or pulse changes.

Reset
REQ-039 On rst_in: all outputs 0 except rob_dispatcher_b_out=1, head=tail=1, count=0, every entry not busy; reset mid-flight discards all entries.

Verification
REQ-040 Reset, dispatch ADDI x5 -> b_out 1->2; CDB tag1 value 7 -> next cycle regfile_en, rd 5, value 7, tag 1.
REQ-041 Dispatch 15 entries -> full_out 1, 16th dispatch ignored; commit one -> full_out 0, next allocation gets tag 1 (wrap).
REQ-042 Lookup tag 3 in same cycle as CDB tag3 value 0x55 -> rs_ready 1, rs_value 0x55; lookup tag 0 -> ready 0.
REQ-043 BEQ pc 0x100 taken, target 0x140, CDB npc 0x104 -> flush pulse, flush_pc 0x104, b_out 1, count 0; same-cycle dispatch dropped.
REQ-044 Store at head ready with rdy_in low 3 cycles -> no pulse; rdy_in high -> store_en with correct tag, no regfile write.
